// File: rtl/mem_port_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_pkg
// Types and helpers shared by the memory port arbiter and its sub-blocks.
// Rev    : 1.0  initial release
// ============================================================================
package mem_port_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // A single channel still needs a 1-bit index to keep vectors legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Combinational round-robin pick: first request found after the pointer.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import mem_port_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int IDX_W = idx_width(NCH)
) (
  input  logic [NCH-1:0]   i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NCH-1:0]   o_grant,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_any
);

  function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] ptr, input int ofs);
    int s;
    s = (int'(ptr) + ofs) % NCH;
    return IDX_W'(s);
  endfunction

  // Offset NCH lands back on the pointer itself, so it has lowest priority.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!o_any && i_req[rr_slot(i_ptr, k)]) begin
        o_any                       = 1'b1;
        o_grant_idx                 = rr_slot(i_ptr, k);
        o_grant[rr_slot(i_ptr, k)]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Round-robin arbiter of NCH requesters onto one synchronous memory port.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int NCH    = 2,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_we,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  input  logic [NCH*DATA_W-1:0] req_wdata,
  output logic [NCH-1:0]        req_ready,
  output logic [NCH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int               IDX_W    = idx_width(NCH);
  localparam int               CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_ch;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [NCH-1:0]     w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;

  rr_arbiter #(
    .NCH   (NCH),
    .IDX_W (IDX_W)
  ) u_rr (
    .i_req       (req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    busy        = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        mem_re      = ~r_we;
        w_state_nxt = r_we ? RESP : WAIT;
      end
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
      end
      RESP: begin
        rsp_valid   = NCH'(1) << r_ch;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latched request, wait counter and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= IDX_W'(NCH - 1);
      r_ch    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr   <= w_grant_idx;
            r_ch    <= w_grant_idx;
            r_we    <= req_we[w_grant_idx];
            r_addr  <= req_addr[int'(w_grant_idx) * ADDR_W +: ADDR_W];
            r_wdata <= req_wdata[int'(w_grant_idx) * DATA_W +: DATA_W];
          end
        end
        ISSUE: begin
          if (r_we) r_rdata <= '0;
          else      r_cnt   <= CNT_LOAD;
        end
        WAIT: begin
          if (r_cnt == '0) r_rdata <= mem_rdata;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Directed bench over four arbiter configurations sharing one request bus.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int NI = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           req_valid;
  logic [2:0]           req_we;
  logic [3*AW-1:0]      req_addr;
  logic [3*DW-1:0]      req_wdata;
  logic [NI-1:0][2:0]   ready;
  logic [NI-1:0][2:0]   rspv;
  logic [NI-1:0][DW-1:0] rdata;
  logic [NI-1:0][DW-1:0] mwdata;
  logic [NI-1:0][DW-1:0] mrdata;
  logic [NI-1:0][AW-1:0] maddr;
  logic [NI-1:0]        en;
  logic [NI-1:0]        we;
  logic [NI-1:0]        re;
  logic [NI-1:0]        busy;
  logic [AW+DW-1:0]     wlog [$];
  int                   n_cmp = 0;
  int                   n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: NCH=3, RD_LAT=3. Instances 1..3: NCH=2, RD_LAT=1,2,4.
  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int N   = (k == 0) ? 3 : 2;
    localparam int LAT = (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 2 : 4;
    logic [N-1:0]  rdy_l;
    logic [N-1:0]  rv_l;
    logic [DW-1:0] mem [64];
    logic [DW-1:0] pd  [4];
    logic [3:0]    pv;

    mem_port_arbiter #(
      .DATA_W (DW),
      .ADDR_W (AW),
      .NCH    (N),
      .RD_LAT (LAT)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[N-1:0]),
      .req_we    (req_we[N-1:0]),
      .req_addr  (req_addr[N*AW-1:0]),
      .req_wdata (req_wdata[N*DW-1:0]),
      .req_ready (rdy_l),
      .rsp_valid (rv_l),
      .rsp_rdata (rdata[k]),
      .mem_en    (en[k]),
      .mem_we    (we[k]),
      .mem_re    (re[k]),
      .mem_addr  (maddr[k]),
      .mem_wdata (mwdata[k]),
      .mem_rdata (mrdata[k]),
      .busy      (busy[k])
    );

    assign ready[k]  = 3'(rdy_l);
    assign rspv[k]   = 3'(rv_l);
    // Data is only meaningful in the exact sample cycle; poison otherwise.
    assign mrdata[k] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= {16'hA5A5, 16'(i)};
        mem[16] <= 32'hDEADBEEF;
        pv      <= '0;
      end else begin
        if (en[k] && we[k]) mem[maddr[k][5:0]] <= mwdata[k];
        pv    <= {pv[2:0], en[k] & re[k]};
        pd[0] <= mem[maddr[k][5:0]];
        for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && en[1] && we[1]) wlog.push_back({maddr[1], mwdata[1]});
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 1 : (k == 2) ? 2 : 4;
  endfunction

  function automatic logic [2:0] oh(input int c);
    return 3'(1 << c);
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int ch);
    return (ch == 0) ? 32'hDEADBEEF : {16'hA5A5, 16'(16 + ch)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ch, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[ch]          = v;
    req_we[ch]             = w;
    req_addr[ch*AW +: AW]  = a;
    req_wdata[ch*DW +: DW] = d;
  endtask

  task automatic settle();
    req_valid = '0;
    repeat (12) step();
  endtask

  task automatic test_reset_state();
    n_cmp++; if (busy !== '0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if ({en, we, re} !== '0) begin n_err++; $display("FAIL rst_mem_ctl: got %b expected 0", {en, we, re}); end
    n_cmp++; if (ready !== '0) begin n_err++; $display("FAIL rst_ready: got %h expected 0", ready); end
    n_cmp++; if (rspv !== '0) begin n_err++; $display("FAIL rst_rsp_valid: got %h expected 0", rspv); end
    n_cmp++; if (maddr !== '0) begin n_err++; $display("FAIL rst_mem_addr: got %h expected 0", maddr); end
    n_cmp++; if (mwdata !== '0) begin n_err++; $display("FAIL rst_mem_wdata: got %h expected 0", mwdata); end
    n_cmp++; if (rdata !== '0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h expected 0", rdata); end
  endtask

  task automatic test_contention();
    int gq[$];
    int ng = 0, nr = 0, cyc = 0, last = 0, ch;
    for (int c = 0; c < 3; c++) drive(c, 1'b1, 1'b0, 14'(16 + c), '0);
    #1;
    while ((ng < 6 || nr < 6) && cyc < 80) begin
      n_cmp++;
      if ((ready[0] & {3{busy[0]}}) !== 3'b000) begin
        n_err++; $display("FAIL cont_grant_while_busy: got %b expected 000", ready[0]);
      end
      if (ready[0] !== 3'b000) begin
        n_cmp++;
        if (ready[0] !== oh(ng % 3)) begin
          n_err++; $display("FAIL cont_order: got %b expected %b", ready[0], oh(ng % 3));
        end
        if (ng > 0) begin
          n_cmp++;
          if (cyc - last != 6) begin n_err++; $display("FAIL cont_spacing: got %0d expected 6", cyc - last); end
        end
        last = cyc;
        gq.push_back(ng % 3);
        ng++;
      end
      if (rspv[0] !== 3'b000 && gq.size() > 0) begin
        ch = gq.pop_front();
        n_cmp++;
        if (rspv[0] !== oh(ch)) begin n_err++; $display("FAIL cont_rsp_valid: got %b expected %b", rspv[0], oh(ch)); end
        n_cmp++;
        if (rdata[0] !== exp_rd(ch)) begin n_err++; $display("FAIL cont_rdata: got %h expected %h", rdata[0], exp_rd(ch)); end
        nr++;
      end
      step();
      cyc++;
      if (ng == 6) req_valid = '0;
    end
    n_cmp++;
    if (ng != 6 || nr != 6) begin
      n_err++; $display("FAIL cont_timeout: got %0d grants %0d rsps expected 6 6", ng, nr);
    end
  endtask

  task automatic test_single_write();
    drive(1, 1'b1, 1'b1, 14'h0010, 32'hDEADBEEF);
    #1;
    n_cmp++; if (ready[1] !== 3'b010) begin n_err++; $display("FAIL wr_ready: got %b expected 010", ready[1]); end
    step();
    drive(1, 1'b0, 1'b0, '0, '0);
    n_cmp++; if ({en[1], we[1], re[1]} !== 3'b110) begin n_err++; $display("FAIL wr_mem_ctl: got %b expected 110", {en[1], we[1], re[1]}); end
    n_cmp++; if (maddr[1] !== 14'h0010) begin n_err++; $display("FAIL wr_mem_addr: got %h expected 0010", maddr[1]); end
    n_cmp++; if (mwdata[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_mem_wdata: got %h expected deadbeef", mwdata[1]); end
    step();
    n_cmp++; if (rspv[1] !== 3'b010) begin n_err++; $display("FAIL wr_rsp_valid: got %b expected 010", rspv[1]); end
    n_cmp++; if (rdata[1] !== 32'h0) begin n_err++; $display("FAIL wr_rsp_rdata: got %h expected 0", rdata[1]); end
  endtask

  task automatic test_read_latency();
    logic [2:0] exp;
    drive(0, 1'b1, 1'b0, 14'h0010, '0);
    #1;
    for (int k = 1; k < NI; k++) begin
      n_cmp++; if (ready[k] !== 3'b001) begin n_err++; $display("FAIL lat_ready[%0d]: got %b expected 001", k, ready[k]); end
    end
    step();
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int n = 1; n <= 7; n++) begin
      for (int k = 1; k < NI; k++) begin
        exp = (n == 2 + lat_of(k)) ? 3'b001 : 3'b000;
        n_cmp++;
        if (rspv[k] !== exp) begin n_err++; $display("FAIL lat_rsp_valid[%0d] t+%0d: got %b expected %b", k, n, rspv[k], exp); end
        if (exp != 3'b000) begin
          n_cmp++;
          if (rdata[k] !== 32'hDEADBEEF) begin n_err++; $display("FAIL lat_rdata[%0d]: got %h expected deadbeef", k, rdata[k]); end
        end
      end
      step();
    end
  endtask

  task automatic test_withdraw();
    logic [2:0] exp;
    drive(0, 1'b1, 1'b0, 14'h0010, '0);
    #1;
    n_cmp++; if (ready[0] !== 3'b001) begin n_err++; $display("FAIL wd_ready: got %b expected 001", ready[0]); end
    step();
    drive(0, 1'b0, 1'b0, '0, '0);
    step();
    drive(2, 1'b1, 1'b0, 14'h0012, '0);
    #1;
    n_cmp++; if (ready[0] !== 3'b000) begin n_err++; $display("FAIL wd_ready_busy: got %b expected 000", ready[0]); end
    n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL wd_busy: got %b expected 1", busy[0]); end
    step();
    step();
    drive(2, 1'b0, 1'b0, '0, '0);
    for (int n = 4; n <= 12; n++) begin
      exp = (n == 5) ? 3'b001 : 3'b000;
      n_cmp++; if (ready[0] !== 3'b000) begin n_err++; $display("FAIL wd_no_grant t+%0d: got %b expected 000", n, ready[0]); end
      n_cmp++; if (rspv[0] !== exp) begin n_err++; $display("FAIL wd_rsp_valid t+%0d: got %b expected %b", n, rspv[0], exp); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, cyc = 0, last = 0;
    logic [AW+DW-1:0] e;
    wlog.delete();
    drive(0, 1'b1, 1'b1, 14'h0020, {16'hC0DE, 16'h0000});
    #1;
    while (n < 8 && cyc < 40) begin
      if (ready[1][0] === 1'b1) begin
        if (n > 0) begin
          n_cmp++;
          if (cyc - last != 3) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - last); end
        end
        last = cyc;
        n++;
        step();
        cyc++;
        if (n == 8) drive(0, 1'b0, 1'b0, '0, '0);
        else        drive(0, 1'b1, 1'b1, 14'(32 + n), {16'hC0DE, 16'(n)});
      end else begin
        step();
        cyc++;
      end
    end
    n_cmp++; if (n != 8) begin n_err++; $display("FAIL b2b_timeout: got %0d accepts expected 8", n); end
    repeat (5) step();
    n_cmp++; if (wlog.size() != 8) begin n_err++; $display("FAIL b2b_wr_count: got %0d expected 8", wlog.size()); end
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      e = {14'(32 + i), 16'hC0DE, 16'(i)};
      n_cmp++;
      if (wlog[i] !== e) begin n_err++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, wlog[i], e); end
    end
  endtask

  task automatic test_reset_midread();
    logic [2:0] exp;
    drive(0, 1'b1, 1'b0, 14'h0010, '0);
    step();
    drive(0, 1'b0, 1'b0, '0, '0);
    step();
    n_cmp++; if (busy[0] !== 1'b1) begin n_err++; $display("FAIL mrst_pre_busy: got %b expected 1", busy[0]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (busy[0] !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b expected 0", busy[0]); end
    n_cmp++; if (ready[0] !== 3'b000) begin n_err++; $display("FAIL mrst_ready: got %b expected 000", ready[0]); end
    n_cmp++; if (rspv[0] !== 3'b000) begin n_err++; $display("FAIL mrst_rsp_valid: got %b expected 000", rspv[0]); end
    n_cmp++; if ({en[0], we[0], re[0]} !== 3'b000) begin n_err++; $display("FAIL mrst_mem_ctl: got %b expected 000", {en[0], we[0], re[0]}); end
    n_cmp++; if (maddr[0] !== '0) begin n_err++; $display("FAIL mrst_mem_addr: got %h expected 0", maddr[0]); end
    n_cmp++; if (rdata[0] !== '0) begin n_err++; $display("FAIL mrst_rdata: got %h expected 0", rdata[0]); end
    step();
    rst = 1'b0;
    step();
    for (int c = 0; c < 3; c++) drive(c, 1'b1, 1'b0, 14'(16 + c), '0);
    #1;
    n_cmp++; if (ready[0] !== 3'b001) begin n_err++; $display("FAIL mrst_first_grant: got %b expected 001", ready[0]); end
    step();
    req_valid = '0;
    for (int n = 1; n <= 7; n++) begin
      exp = (n == 5) ? 3'b001 : 3'b000;
      n_cmp++; if (rspv[0] !== exp) begin n_err++; $display("FAIL mrst_rsp_valid t+%0d: got %b expected %b", n, rspv[0], exp); end
      step();
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) step();
    test_reset_state();
    rst = 1'b0;
    step();
    test_contention();
    settle();
    test_single_write();
    settle();
    test_read_latency();
    settle();
    test_withdraw();
    settle();
    test_back_to_back();
    settle();
    test_reset_midread();
    settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
